unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Arbitrates one single-port synchronous SRAM (1-cycle read latency, active-low chip select and write enable) between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage core. Data accesses win by default. A starvation counter forces a fetch grant after a bounded run of data wins. The block drives a pipeline-stall enable to freeze all stages whenever a requester is refused in the current cycle.

## Interface
- ADDR_W, 10, word address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive contended data grants before fetch is forced (legal 1..15)

- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous, active-low reset
- EN  in  1  global enable; low = no new grants
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DATA_W  load data
- mem_csb  out  1  SRAM chip select, active low
- mem_web  out  1  SRAM write enable, active low
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read select
- stall_n  out  1  0 = freeze pipeline registers this cycle

## Operation
- **Grant (combinational, same cycle as request)**
  - No grant if EN=0.
  - If only one requester is active, grant it.
  - If both are active, grant data unless starve_cnt == STARVE_MAX; in that case grant fetch.
  - At most one grant per cycle.
- **SRAM drive**
  - Granted: mem_csb=0. mem_addr and mem_wdata come from the winner. mem_web=0 only for a granted store.
  - No grant: mem_csb=1, mem_web=1, mem_addr=0, mem_wdata=0.
- **State register** (records the transaction issued last cycle):
  - States: ARB_IDLE, ARB_IF_RD, ARB_DM_RD, ARB_DM_WR.
  - Next state is set by this cycle's grant type; no grant → ARB_IDLE.
  - Back-to-back grants are allowed in any order.
- **Read return**
  - if_rvalid=1 only in ARB_IF_RD; dm_rvalid=1 only in ARB_DM_RD.
  - x_rdata = mem_rdata when the matching rvalid=1, else 0.
  - Stores produce no rvalid. The store completes at the clock edge that samples dm_gnt=1.
- **Starvation counter** (0..STARVE_MAX):
  - Increments on each cycle with if_req=1, dm_gnt=1 and if_gnt=0.
  - Clears on if_gnt=1 or if_req=0.
  - Holds when EN=0.
- **Stall**: stall_n = !((if_req & !if_gnt) | (dm_req & !dm_gnt)). A requester must hold req, addr, we and wdata stable until granted.
- **EN=0 mid-operation**
  - A read granted in the previous cycle still returns its rvalid and data.
  - stall_n is driven low by any pending request.
- **Reset (asynchronous)**
  - State → ARB_IDLE; starve_cnt → 0.
  - An in-flight read is dropped: no rvalid after reset release.

## Timing
- Output values while RSTn=0:
  - if_gnt=0, dm_gnt=0, if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0
  - mem_csb=1, mem_web=1, mem_addr=0, mem_wdata=0
  - stall_n=1
- While RSTn=0, grants are forced to 0 regardless of requests.
- Grant latency: 0 cycles (combinational).
- Read latency: rvalid arrives exactly 1 cycle after the grant cycle.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX cycles.
- Registered elements: state (2 bits) and starve_cnt (4 bits) only.
- No combinational path from mem_rdata to any grant or stall output.

## Structure
- Add to my_pkg:
  - arb_state_e enum: ARB_IDLE, ARB_IF_RD, ARB_DM_RD, ARB_DM_WR
  - Constant ARB_STARVE_W = 4
- Sub-module arb_starve_cnt: saturating counter with inc/clr/hold controls and a sat_eq output (count == STARVE_MAX).
- The grant mux and read-return demux stay in the top-level module.

## Test plan
- Reset mid-read: grant a fetch read, assert RSTn=0 in the following cycle → no if_rvalid after release; mem_csb=1 and stall_n=1 while reset is held.
- Lone fetch: if_req=1, if_addr=0x004, mem_rdata=0x00500093 on the next cycle → if_gnt=1 at cycle t, if_rvalid=1 with if_rdata=0x00500093 at t+1, stall_n=1 throughout.
- Contention: if_req=dm_req=1 (dm load 0x010) → dm_gnt=1, if_gnt=0, stall_n=0; dm_rvalid=1 at t+1.
- Starvation, STARVE_MAX=4: both requests held continuously → data granted in cycles 0–3, fetch granted in cycle 4, data granted in cycle 5; starve_cnt reads 0 after cycle 4.
- Store, then load to the same address: store 0xDEADBEEF to 0x020 (mem_web=0, no dm_rvalid), then load 0x020 → dm_rdata=0xDEADBEEF.
- EN drop: grant a load, then EN=0 with both requests pending → dm_rvalid still returned; no grants, mem_csb=1, stall_n=0; starve_cnt holds its value.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data SRAM arbiter.
package unified_mem_arbiter_pkg;

    localparam int ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF_RD = 2'd1,
        ARB_DM_RD = 2'd2,
        ARB_DM_WR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data wins over a waiting fetch; sat_eq tells
// the arbiter to hand the next contended slot to fetch.
module arb_starve_cnt
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic sat_eq
);

    localparam logic [ARB_STARVE_W-1:0] MAX_C  = ARB_STARVE_W'(STARVE_MAX);
    localparam logic [ARB_STARVE_W-1:0] ZERO_C = {ARB_STARVE_W{1'b0}};
    localparam logic [ARB_STARVE_W-1:0] ONE_C  = {{(ARB_STARVE_W-1){1'b0}}, 1'b1};

    logic [ARB_STARVE_W-1:0] cnt_r;

    // Counter update: hold beats clear beats increment; never counts past MAX_C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO_C;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (clr) begin
            cnt_r <= ZERO_C;
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat_eq = (cnt_r == MAX_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between fetch (read-only) and the memory stage,
// with data priority, bounded fetch starvation and a pipeline stall enable.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_n
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       if_gnt_s;
    logic       dm_gnt_s;
    logic       sat_eq_s;
    logic       cnt_inc_s;
    logic       cnt_clr_s;
    logic       cnt_hold_s;

    // Grant decision: data wins contention unless fetch has waited STARVE_MAX slots.
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (RSTn && EN) begin
            if_gnt_s = if_req && (!dm_req || sat_eq_s);
            dm_gnt_s = dm_req && !(if_req && sat_eq_s);
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    assign if_gnt = if_gnt_s;
    assign dm_gnt = dm_gnt_s;

    // SRAM port mux; an idle cycle parks every control and data line.
    always_comb begin
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (if_gnt_s) begin
            mem_csb  = 1'b0;
            mem_addr = if_addr;
        end else if (dm_gnt_s) begin
            mem_csb   = 1'b0;
            mem_web   = !dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else begin
            mem_csb = 1'b1;
        end
    end

    // Stall whenever a live requester is refused; reset releases the pipeline.
    always_comb begin
        stall_n = 1'b1;
        if (RSTn) begin
            stall_n = !((if_req && !if_gnt_s) || (dm_req && !dm_gnt_s));
        end else begin
            stall_n = 1'b1;
        end
    end

    // Transaction type issued this cycle, tracked so the read return can be routed.
    always_comb begin
        state_nxt_s = ARB_IDLE;
        if (if_gnt_s) begin
            state_nxt_s = ARB_IF_RD;
        end else if (dm_gnt_s) begin
            state_nxt_s = dm_we ? ARB_DM_WR : ARB_DM_RD;
        end else begin
            state_nxt_s = ARB_IDLE;
        end
    end

    // Issued-transaction register; reset drops any read still in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read return demux: SRAM data is forwarded only to the requester that issued it.
    always_comb begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = {DATA_W{1'b0}};
        dm_rdata  = {DATA_W{1'b0}};
        case (state_r)
            ARB_IF_RD: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            ARB_DM_RD: begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end
            ARB_DM_WR: begin
                dm_rvalid = 1'b0;
            end
            default: begin
                if_rvalid = 1'b0;
                dm_rvalid = 1'b0;
            end
        endcase
    end

    assign cnt_inc_s  = if_req && dm_gnt_s && !if_gnt_s;
    assign cnt_clr_s  = if_gnt_s || !if_req;
    assign cnt_hold_s = !EN;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (CLK),
        .rst_n  (RSTn),
        .inc    (cnt_inc_s),
        .clr    (cnt_clr_s),
        .hold   (cnt_hold_s),
        .sat_eq (sat_eq_s)
    );

endmodule
